// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sample type, layer-1 geometry constants and signed max helper
package cnn_pkg;
  localparam int DATA_W     = 16;
  localparam int L1_MAP_W   = 88;
  localparam int L1_MAP_H   = 88;
  localparam int L1_NUM_OUT = (L1_MAP_W / 2) * (L1_MAP_H / 2);

  typedef logic signed [DATA_W-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/m_line_buf.sv
// m_line_buf: one row of horizontal maxima, sync write, async read, no reset
module m_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = L1_MAP_W / 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     clk_in,
  input  logic                     we_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]            raddr_i,
  output logic signed [DATA_W-1:0] rdata_o
);
  sample_t mem_q [DEPTH];

  // store the even-row horizontal max for its column pair
  always_ff @(posedge clk_in) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/m_relu_pool_1.sv
// m_relu_pool_1: 2x2/stride-2 max pool with optional ReLU (macro RELU_POOL_1_RELU_EN)
module m_relu_pool_1
  import cnn_pkg::*;
#(
  parameter int MAP_W   = L1_MAP_W,
  parameter int MAP_H   = L1_MAP_H,
  parameter int NUM_OUT = L1_NUM_OUT
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] map_in,
  input  logic                     valid_in,
  output logic signed [DATA_W-1:0] map_out,
  output logic                     save,
  output logic                     ready
);
  localparam int CW = $clog2(MAP_W);
  localparam int RW = $clog2(MAP_H);
  localparam int OW = $clog2(NUM_OUT + 1);
  localparam int AW = $clog2(MAP_W / 2);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  sample_t       h_q, h_d, map_out_q, map_out_d;
  logic          save_q, save_d, ready_q, ready_d;
  logic          acc, col_last, row_last, lb_we, emit;
  sample_t       hmax, pmax, act, lb_rd;
  logic [AW-1:0] lb_addr;

  assign lb_addr = col_q[CW-1:1];

  m_line_buf #(.DEPTH(MAP_W / 2), .AW(AW)) u_line_buf (
    .clk_in  (clk_in),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (hmax),
    .raddr_i (lb_addr),
    .rdata_o (lb_rd)
  );

  // next-state: raster counters, horizontal/vertical max, output and frame-done tracking
  always_comb begin
    acc       = valid_in & start & ready_q;
    col_last  = col_q == CW'(MAP_W - 1);
    row_last  = row_q == RW'(MAP_H - 1);
    col_d     = acc ? (col_last ? '0 : col_q + 1'b1) : col_q;
    row_d     = (acc & col_last) ? (row_last ? '0 : row_q + 1'b1) : row_q;
    h_d       = (acc & ~col_q[0]) ? map_in : h_q;
    hmax      = smax(h_q, map_in);
    pmax      = smax(hmax, lb_rd);
`ifdef RELU_POOL_1_RELU_EN
    act       = pmax[DATA_W-1] ? '0 : pmax;
`else
    act       = pmax;
`endif
    lb_we     = acc & col_q[0] & ~row_q[0];
    emit      = acc & col_q[0] & row_q[0];
    save_d    = emit;
    map_out_d = emit ? act : map_out_q;
    out_cnt_d = (emit && out_cnt_q != OW'(NUM_OUT)) ? out_cnt_q + 1'b1 : out_cnt_q;
    ready_d   = ready_q & (out_cnt_q != OW'(NUM_OUT));
  end

  // state register: reset clears all, start low clears all but ready
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      out_cnt_q <= '0;
      h_q       <= '0;
      map_out_q <= '0;
      save_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else if (!start) begin
      col_q     <= '0;
      row_q     <= '0;
      out_cnt_q <= '0;
      h_q       <= '0;
      map_out_q <= '0;
      save_q    <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      out_cnt_q <= out_cnt_d;
      h_q       <= h_d;
      map_out_q <= map_out_d;
      save_q    <= save_d;
      ready_q   <= ready_d;
    end
  end

  assign map_out = map_out_q;
  assign save    = save_q;
  assign ready   = ready_q;
endmodule

// File: tb/tb_m_relu_pool_1.sv
// tb_m_relu_pool_1: directed frames against hand-derived pooled outputs
module tb_m_relu_pool_1;
  localparam int W = 88, H = 88, NUM = 1936, PW = 44;

  logic clk_in = 0, rst_n = 0, start = 0, valid_in = 0;
  logic signed [15:0] map_in = '0;
  logic signed [15:0] map_out;
  logic save, ready;

  int checks = 0, failures = 0;
  int n_saves = 0, falls = 0, cyc = 0, last_save_cyc = 0, fall_cyc = 0;
  logic ready_prev = 1;
  logic [15:0] got [NUM];

  m_relu_pool_1 dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .start   (start),
    .map_in  (map_in),
    .valid_in(valid_in),
    .map_out (map_out),
    .save    (save),
    .ready   (ready)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (save) begin
      if (n_saves < NUM) got[n_saves] = map_out;
      n_saves++;
      last_save_cyc = cyc;
    end
    if (ready_prev && !ready) begin
      falls++;
      fall_cyc = cyc;
    end
    ready_prev = ready;
  end

  function automatic logic signed [15:0] sample(input int kind, input int r, input int c);
    if (kind == 0) return 16'(r * W + c);
    if (kind == 1) return -16'sd5;
    return (r == 3 && c == 5) ? 16'sh7FFF : -16'sd1;
  endfunction

  function automatic logic [15:0] exp_out(input int kind, input int k);
    logic signed [15:0] v;
    int pr, pc;
    pr = k / PW;
    pc = k % PW;
    if (kind == 0) v = 16'((2 * pr + 1) * W + 2 * pc + 1);
    else if (kind == 1) v = -16'sd5;
    else v = (k == 46) ? 16'sh7FFF : -16'sd1;
`ifdef RELU_POOL_1_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_n = 0; start = 0; valid_in = 0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1; start = 1;
    n_saves = 0; falls = 0; ready_prev = 1;
  endtask

  task automatic drive_frame(input int kind, input int gap, input int stop_at);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        valid_in = 1;
        map_in = sample(kind, r, c);
        @(posedge clk_in); #1;
        if (stop_at > 0 && n_saves >= stop_at) begin
          valid_in = 0;
          return;
        end
      end
      valid_in = 0;
      map_in = 16'(16'hA5A5 + r);
      repeat (gap) begin
        @(posedge clk_in); #1;
      end
    end
    valid_in = 0;
  endtask

  task automatic check_frame(input string name, input int kind);
    int bad, first_bad;
    bad = 0;
    first_bad = -1;
    repeat (4) @(posedge clk_in);
    #1;
    for (int k = 0; k < NUM; k++)
      if (k < n_saves && got[k] !== exp_out(kind, k)) begin
        if (first_bad < 0) first_bad = k;
        bad++;
      end
    checks++;
    if (n_saves !== NUM) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", name, n_saves, NUM);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL %s_values bad=%0d first_idx=%0d got=%h exp=%h", name, bad, first_bad,
               got[first_bad], exp_out(kind, first_bad));
    end
    checks++;
    if (falls !== 1) begin
      failures++;
      $display("FAIL %s_ready_falls got=%0d exp=1", name, falls);
    end
    checks++;
    if (fall_cyc !== last_save_cyc + 1) begin
      failures++;
      $display("FAIL %s_ready_timing fall=%0d exp=%0d", name, fall_cyc, last_save_cyc + 1);
    end
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_ready_low got=%b exp=0", name, ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 1;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'($urandom);
      map_in = 16'($urandom);
      @(negedge clk_in);
      checks++;
      if (map_out !== 16'h0 || save !== 1'b0 || ready !== 1'b1) begin
        failures++;
        $display("FAIL reset cycle=%0d map_out=%h save=%b ready=%b exp 0000/0/1", i, map_out, save, ready);
      end
    end
  endtask

  task automatic test_ramp();
    int extra;
    do_reset();
    drive_frame(0, 0, 0);
    check_frame("ramp", 0);
    extra = n_saves;
    drive_frame(0, 0, 0);
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if (n_saves !== extra || ready !== 1'b0) begin
      failures++;
      $display("FAIL post_frame_ignored saves=%0d exp=%0d ready=%b exp=0", n_saves, extra, ready);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    drive_frame(0, 8, 0);
    check_frame("gapped", 0);
  endtask

  task automatic test_neg_const();
    do_reset();
    drive_frame(1, 2, 0);
    check_frame("neg5", 1);
  endtask

  task automatic test_spike();
    do_reset();
    drive_frame(2, 0, 0);
    check_frame("spike", 2);
    checks++;
    if (got[46] !== 16'h7FFF) begin
      failures++;
      $display("FAIL spike_idx46 got=%h exp=7fff", got[46]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_frame(0, 0, 500);
    checks++;
    if (n_saves !== 500 || ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_partial saves=%0d exp=500 ready=%b exp=1", n_saves, ready);
    end
    do_reset();
    drive_frame(0, 0, 0);
    check_frame("mid_reset", 0);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_gapped();
    test_neg_const();
    test_spike();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
